// File: rtl/flt2fix_pkg.sv
// Shared constants, state encoding and the half-float to signed 8.8 conversion rule.
`timescale 1ns/1ps
package flt2fix_pkg;

  localparam int MEM_DEPTH = 256;

  localparam logic [7:0] IN_LO  = 8'd4;
  localparam logic [7:0] IN_HI  = 8'd5;
  localparam logic [7:0] OUT_LO = 8'd6;
  localparam logic [7:0] OUT_HI = 8'd7;

  localparam int BIAS = 15;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // Exponent at which the 10-bit fraction lines up with the 8 output fraction bits.
  localparam logic [4:0] E_ALIGN = 5'(BIAS + 10 - 8);
  localparam logic [4:0] E_SAT   = 5'(BIAS + 10 - 8 + 6);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_HI,
    S_LD_LO,
    S_CALC,
    S_ST_LO,
    S_ST_HI,
    S_DONE
  } state_t;

  function automatic logic [15:0] f16_to_q88(input logic [15:0] h);
    logic        s;
    logic [4:0]  e;
    logic [10:0] m;
    logic [23:0] mag;
    logic [15:0] m16;
    logic        sat;
    s = h[15];
    e = h[14:10];
    m = {(e != 5'd0), h[9:0]};
    if (e >= E_ALIGN)
      mag = {13'd0, m} << (e - E_ALIGN);
    else
      mag = {13'd0, m} >> (E_ALIGN - e);
    sat = (e >= E_SAT) || (!s && (mag > 24'd32767)) || (s && (mag > 24'd32768));
    m16 = mag[15:0];
    if (sat)
      return s ? SAT_NEG : SAT_POS;
    else
      return s ? (~m16 + 16'd1) : m16;
  endfunction

endpackage

// File: rtl/dat_mem.sv
// 256x8 data memory: combinational read, synchronous single-byte write, no reset.
`timescale 1ns/1ps
module dat_mem
  import flt2fix_pkg::*;
(
  input  logic       Clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] Core [0:MEM_DEPTH-1];

  always_ff @(posedge Clk) begin
    if (we_i)
      Core[waddr_i] <= wdata_i;
  end

  assign rdata_o = Core[raddr_i];

endmodule

// File: rtl/top_level.sv
// Float16 -> signed 8.8 converter: loads bytes 5/4, converts, stores bytes 6/7, raises Return.
// state   | meaning
// IDLE    | waiting for Start
// LD_HI   | latch operand high byte (Core[5])
// LD_LO   | latch operand low byte (Core[4])
// CALC    | register converted result
// ST_LO   | write result low byte (Core[6])
// ST_HI   | write result high byte (Core[7])
// DONE    | raise and hold Return; Start relaunches
`timescale 1ns/1ps
module top_level
  import flt2fix_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Return
);

  state_t      state_q;
  logic [7:0]  hi_q;
  logic [7:0]  lo_q;
  logic [15:0] res_q;
  logic        ret_q;

  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_raddr;
  logic [7:0]  mem_rdata;
  logic [15:0] res_d;

  always_comb begin
    mem_raddr = (state_q == S_LD_HI) ? IN_HI : IN_LO;
    mem_we    = (state_q == S_ST_LO) || (state_q == S_ST_HI);
    mem_waddr = (state_q == S_ST_HI) ? OUT_HI : OUT_LO;
    mem_wdata = (state_q == S_ST_HI) ? res_q[15:8] : res_q[7:0];
    res_d     = f16_to_q88({hi_q, lo_q});
  end

  dat_mem DM1 (
    .Clk     (Clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      hi_q    <= 8'd0;
      lo_q    <= 8'd0;
      res_q   <= 16'd0;
      ret_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (Start) state_q <= S_LD_HI;
        S_LD_HI: begin
          hi_q    <= mem_rdata;
          state_q <= S_LD_LO;
        end
        S_LD_LO: begin
          lo_q    <= mem_rdata;
          state_q <= S_CALC;
        end
        S_CALC: begin
          res_q   <= res_d;
          state_q <= S_ST_LO;
        end
        S_ST_LO: state_q <= S_ST_HI;
        S_ST_HI: state_q <= S_DONE;
        S_DONE: begin
          // Return is raised one cycle into DONE so both result bytes have settled.
          if (Start) begin
            ret_q   <= 1'b0;
            state_q <= S_LD_HI;
          end else begin
            ret_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Return = ret_q;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: directed vector table, randomized operands vs a real-valued model, control sequences.
`timescale 1ns/1ps
module tb_top_level;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
  logic Return;

  int n_pass = 0;
  int n_total = 0;

  top_level dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Return (Return)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] op;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: real value of the half float scaled by 256, truncated toward zero, clamped.
  function automatic logic [15:0] ref_q88(input logic [15:0] h);
    int  e;
    int  f;
    real v;
    int  t;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 31) return h[15] ? 16'h8000 : 16'h7FFF;
    if (e == 0) v = f * (2.0 ** (-24));
    else        v = (1024 + f) * (2.0 ** (e - 25));
    t = $rtoi(v * 256.0);
    if (h[15]) t = -t;
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return 16'(t);
  endfunction

  task automatic load(input logic [15:0] x);
    dut.DM1.Core[4] = x[7:0];
    dut.DM1.Core[5] = x[15:8];
  endtask

  function automatic logic [15:0] read_out();
    return {dut.DM1.Core[7], dut.DM1.Core[6]};
  endfunction

  task automatic do_reset();
    @(posedge Clk);
    #2 Reset = 1'b0;
    Start = 1'b0;
    @(posedge Clk);
    #2 Reset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  // Entered #1 after an edge; returns #1 after the edge that sampled Start.
  task automatic pulse_start();
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk);
      #1;
      if (Return === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic convert(input logic [15:0] x, output logic [15:0] y, output int lat);
    do_reset();
    load(x);
    pulse_start();
    wait_done(lat);
    y = read_out();
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] y;
    logic [15:0] op;
    int lat;
    int tmp;
    logic seen;

    vecs = '{
      '{16'h0000, 16'h0000}, '{16'h3C00, 16'h0100}, '{16'h3E00, 16'h0180},
      '{16'h4040, 16'h0220}, '{16'h4B00, 16'h0E00}, '{16'h8000, 16'h0000},
      '{16'hBC00, 16'hFF00}, '{16'hC040, 16'hFDE0}, '{16'hCB00, 16'hF200},
      '{16'h3C01, 16'h0100}, '{16'hBC01, 16'hFF00}, '{16'h0001, 16'h0000},
      '{16'h1BFF, 16'h0000}, '{16'h1C00, 16'h0001}, '{16'h6300, 16'h7FFF},
      '{16'h7B80, 16'h7FFF}, '{16'h7C00, 16'h7FFF}, '{16'hE300, 16'h8000},
      '{16'hFB80, 16'h8000}, '{16'h5BFF, 16'h7FFF}, '{16'hDBFF, 16'h8000},
      '{16'h5800, 16'h7FFF}, '{16'hD800, 16'h8000}, '{16'h57FF, 16'h7FF0},
      '{16'hFE00, 16'h8000}
    };

    Reset = 1'b0;
    #12;
    chk("reset_return", 32'(Return), 32'd0);

    foreach (vecs[i]) begin
      convert(vecs[i].op, y, lat);
      chk($sformatf("vec_%04h", vecs[i].op), 32'(y), 32'(vecs[i].exp));
      chk($sformatf("lat_%04h", vecs[i].op), 32'(lat), 32'd6);
    end

    for (int i = 0; i < 30; i++) begin
      tmp = $urandom_range(0, 3);
      if (tmp == 0) op = 16'($urandom_range(0, 65535));
      else op = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 24)), 10'($urandom_range(0, 1023))};
      convert(op, y, lat);
      chk($sformatf("rand_%04h", op), 32'(y), 32'(ref_q88(op)));
    end

    // Return timing edge by edge.
    do_reset();
    load(16'h3C00);
    pulse_start();
    for (int i = 1; i <= 6; i++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("ret_edge%0d", i), 32'(Return), (i == 6) ? 32'd1 : 32'd0);
    end

    // Start while busy must be ignored.
    do_reset();
    load(16'h4040);
    pulse_start();
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    pulse_start();
    wait_done(lat);
    chk("busy_start_lat", 32'(lat), 32'd3);
    seen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      if (Return !== 1'b1) seen = 1'b0;
    end
    chk("busy_start_hold", 32'(seen), 32'd1);
    chk("busy_start_res", 32'(read_out()), 32'h0220);

    // Reset asserted while Return is high clears it before the next edge.
    convert(16'hC040, y, lat);
    #2 Reset = 1'b0;
    #1;
    chk("async_clear", 32'(Return), 32'd0);
    #2 Reset = 1'b1;
    @(posedge Clk); #1;

    // Reset mid-conversion: operand bytes untouched, no completion afterwards.
    load(16'h4B00);
    pulse_start();
    @(posedge Clk); #1;
    @(posedge Clk); #2;
    Reset = 1'b0;
    #1;
    chk("mid_ret", 32'(Return), 32'd0);
    chk("mid_core4", 32'(dut.DM1.Core[4]), 32'h00);
    chk("mid_core5", 32'(dut.DM1.Core[5]), 32'h4B);
    @(posedge Clk);
    #2 Reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (Return !== 1'b0) seen = 1'b1;
    end
    chk("mid_idle", 32'(seen), 32'd0);

    // Back-to-back from DONE.
    convert(16'h3C00, y, lat);
    chk("b2b_first", 32'(y), 32'h0100);
    load(16'hCB00);
    pulse_start();
    chk("b2b_ret_drop", 32'(Return), 32'd0);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd6);
    chk("b2b_res", 32'(read_out()), 32'hF200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
